// File: rtl/mem_req_collector.sv
// mem_req_collector: ring-token front end for the coherent memory-model FSM.
// It pushes every accepted Address token into the memory op queue. For a flush
// it also gathers the next 8 WriteData words from the same dest into two
// 128-bit beats. If the words stop arriving, the missing words are zero-padded.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_*_i / req_ready_o   ring token handshake (valid/dest/type/data)
//   mem_op_qfull_i          memory op queue full
//   wr_mem_op_o             memory op queue push
//   mem_op_out_o            memory op queue push data {dest, data}
//   write_data_qfull_i      write data queue full
//   wr_write_data_o         write data queue push
//   write_data_out_o        write data queue push data (one 128-bit beat)
//   err_drop_o              pulse: a token was dropped
//   err_timeout_o           pulse: a flush is being padded
//   drop_count_o            saturating count of dropped tokens
module mem_req_collector #(
    parameter logic [3:0] ADDRESS_TYPE   = 4'h1,
    parameter logic [3:0] WRITEDATA_TYPE = 4'h2,
    parameter logic [7:0] TIMEOUT        = 8'd255
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [3:0]   req_dest_i,
    input  logic [3:0]   req_type_i,
    input  logic [31:0]  req_data_i,
    input  logic         mem_op_qfull_i,
    output logic         wr_mem_op_o,
    output logic [35:0]  mem_op_out_o,
    input  logic         write_data_qfull_i,
    output logic         wr_write_data_o,
    output logic [127:0] write_data_out_o,
    output logic         err_drop_o,
    output logic         err_timeout_o,
    output logic [15:0]  drop_count_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, PAD} state_t;
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    lock_q, lock_d;
    logic [7:0]    timer_q, timer_d;
    logic [95:0]   beat_q, beat_d;
    logic [15:0]   drop_q, drop_d;
    logic          is_addr, is_wd, accept;
    assign is_addr      = req_type_i == ADDRESS_TYPE;
    assign is_wd        = req_type_i == WRITEDATA_TYPE;
    assign accept       = req_valid_i & req_ready_o;
    assign drop_count_o = drop_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lock_q  <= '0;
            timer_q <= '0;
            beat_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            timer_q <= timer_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
        end
    end
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        lock_d           = lock_q;
        timer_d          = timer_q;
        beat_d           = beat_q;
        drop_d           = drop_q;
        req_ready_o      = 1'b0;
        wr_mem_op_o      = 1'b0;
        mem_op_out_o     = '0;
        wr_write_data_o  = 1'b0;
        write_data_out_o = '0;
        err_drop_o       = 1'b0;
        err_timeout_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The state is already IDLE while reset is held, so the gate keeps every output low.
                req_ready_o = rst_ni & (~is_addr | ~mem_op_qfull_i);
                if (accept && is_addr) begin
                    wr_mem_op_o  = 1'b1;
                    mem_op_out_o = {req_dest_i, req_data_i};
                    if (!req_data_i[28]) begin
                        lock_d  = req_dest_i;
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = COLLECT;
                    end
                end else if (accept) begin
                    err_drop_o = 1'b1;
                    drop_d     = &drop_q ? drop_q : drop_q + 16'd1;
                end
            end
            COLLECT: begin
                // The last word of a beat is taken only when its beat can be pushed in the same cycle.
                req_ready_o = is_wd & (req_dest_i == lock_q) &
                              ((cnt_q[1:0] != 2'd3) | ~write_data_qfull_i);
                if (accept) begin
                    timer_d = '0;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        wr_write_data_o  = 1'b1;
                        write_data_out_o = {req_data_i, beat_q};
                        beat_d           = '0;
                    end else begin
                        beat_d[32*cnt_q[1:0] +: 32] = req_data_i;
                    end
                    if (cnt_q == 3'd7) state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_d == TIMEOUT) begin
                        err_timeout_o = 1'b1;
                        state_d       = PAD;
                    end
                end
            end
            PAD: begin
                // Slots that were never written are still zero, so the beat register is already padded.
                if (!write_data_qfull_i) begin
                    wr_write_data_o  = 1'b1;
                    write_data_out_o = {32'h0, beat_q};
                    beat_d           = '0;
                    cnt_d            = cnt_q[2] ? 3'd0 : 3'd4;
                    if (cnt_q[2]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
